branch_pred_ctrl: RTL

Branch-prediction controller sitting between the fetch (IF) and decode (ID) stages of the 5-stage MIPS core. It owns a table of 2-bit saturating predictors indexed by PC and answers the IF-stage "predict taken?" query. It remembers each prediction until the branch resolves in ID, trains the table, and raises a one-cycle flush on misprediction. After reset it sweeps the table to a known state, holding fetch busy, and it keeps branch/mispredict performance counters.

---
 rtl/branch_pred_ctrl_pkg.sv | 22 ++
 rtl/branch_pred_ctrl_bht_table.sv | 32 +++
 rtl/branch_pred_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings for the branch-prediction controller: 2-bit predictor states,
// FSM state codes and the saturating predictor update.
package branch_pred_ctrl_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_bht_table.sv
// Branch history table: 2-bit entries, one asynchronous read port and one
// synchronous write port shared between the init sweep and training.
module bht_table #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  init_we,
    input  logic [INDEX_BITS-1:0] init_idx,
    input  logic [1:0]            init_data,
    input  logic                  train_we,
    input  logic [INDEX_BITS-1:0] train_idx,
    input  logic [1:0]            train_data,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [1:0]            rd_data
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

    logic [1:0] mem [ENTRIES];

    // The sweep owns the port while it runs; training never overlaps it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end else if (train_we) begin
            mem[train_idx] <= train_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch-prediction controller between IF and ID: table lookup, IF->ID shadow,
// resolve/training, misprediction flush, init sweep and performance counters.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 6,
    parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
    parameter logic [1:0]  INIT_STATE  = WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        if_is_branch,
    input  logic        id_taken,
    output logic        pred_taken,
    output logic        flush,
    output logic        busy,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [31:0] CNT_MAX = 32'hffff_ffff;

    state_t                state_q;
    logic [INDEX_BITS-1:0] sweep_idx_q;

    logic                  sh_branch_q;
    logic                  sh_pred_q;
    logic [INDEX_BITS-1:0] sh_idx_q;
    logic [1:0]            sh_ctr_q;

    logic [INDEX_BITS-1:0] if_idx;
    logic [1:0]            rd_ctr;
    logic [1:0]            trained_ctr;
    logic [1:0]            load_ctr;
    logic                  running;
    logic                  if_branch;
    logic                  resolve;

    assign if_idx    = if_pc[INDEX_BITS+1:2];
    assign running   = (state_q == S_RUN);
    assign if_branch = if_valid & if_is_branch;
    assign resolve   = running & sh_branch_q & ~stall;

    assign pred_taken  = running & if_branch & (if_pc < MAX_INSADDR) & rd_ctr[1];
    assign flush       = resolve & (id_taken != sh_pred_q);
    assign busy        = ~running;
    assign trained_ctr = sat_update(sh_ctr_q, id_taken);

    // The shadow keeps the counter value so training needs no second read port;
    // forward the in-flight training write when it hits the same entry.
    assign load_ctr = (resolve && (sh_idx_q == if_idx)) ? trained_ctr : rd_ctr;

    bht_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_bht_table (
        .clk        (clk),
        .init_we    (~running & ~rst),
        .init_idx   (sweep_idx_q),
        .init_data  (INIT_STATE),
        .train_we   (resolve & ~rst),
        .train_idx  (sh_idx_q),
        .train_data (trained_ctr),
        .rd_idx     (if_idx),
        .rd_data    (rd_ctr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            sweep_idx_q <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    sweep_idx_q <= sweep_idx_q + INDEX_BITS'(1);
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: state_q <= S_RUN;
                default: state_q <= S_INIT;
            endcase
        end
    end

    // A flush squashes the IF instruction, so its shadow entry is dropped.
    always_ff @(posedge clk) begin
        if (rst || !running || flush) begin
            sh_branch_q <= 1'b0;
            sh_pred_q   <= 1'b0;
            sh_idx_q    <= '0;
            sh_ctr_q    <= SNT;
        end else if (!stall) begin
            sh_branch_q <= if_branch;
            sh_pred_q   <= pred_taken;
            sh_idx_q    <= if_idx;
            sh_ctr_q    <= load_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (resolve) begin
            if (br_count != CNT_MAX) begin
                br_count <= br_count + 32'd1;
            end
            if (flush && (mis_count != CNT_MAX)) begin
                mis_count <= mis_count + 32'd1;
            end
        end
    end

endmodule
